serial_add_unit: RTL

SERIAL_ADD_UNIT -- requirements
Module: serial_add_unit

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/adder.sv | 13 +
 rtl/serial_add_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: controller state encoding.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// 1-bit full adder: c = a ^ b ^ carry_in, carry_out = majority(a, b, carry_in).
module adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic c,
    output logic carry_out
);

    assign c         = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial unsigned adder, one bit pair per cycle LSB first, valid/ready on both sides.
// Optional SERIAL_ADD_OVF_EN adds a two's-complement overflow output.
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_out_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               last_bit;
    logic               fa_c;
    logic               fa_carry;

    adder u_adder (
        .a         (a_reg[0]),
        .b         (b_reg[0]),
        .carry_in  (carry_reg),
        .c         (fa_c),
        .carry_out (fa_carry)
    );

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == IDLE);
            out_valid_reg <= (state_next == DONE);
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carry_in;
                        cnt_reg   <= '0;
                    end
                end
                SHIFT: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= fa_carry;
                    acc_reg   <= {fa_c, acc_reg[WIDTH-1:1]};
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    // Result lands in the output register only on the final bit, so sum stays put elsewhere.
                    if (last_bit) begin
                        sum_reg       <= {fa_c, acc_reg[WIDTH-1:1]};
                        carry_out_reg <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

`ifdef SERIAL_ADD_OVF_EN
    logic overflow_reg;

    // carry_reg holds the carry into the MSB while the last bit is being added.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (state_reg == SHIFT && last_bit) begin
            overflow_reg <= carry_reg ^ fa_carry;
        end
    end

    assign overflow = overflow_reg;
`endif

endmodule
